imem_prog_loader: RTL and testbench
===================================

Name: imem_prog_loader

Overview:
Byte-stream program loader: the writer side of the CPU's instruction memory. Accepts a framed byte stream from a serial receiver over a valid/ready handshake and packs it into 32-bit instructions. Writes each instruction into instruction memory through a one-cycle write port, and holds the CPU in reset while a load is in progress. Sits between the UART receiver and the CPU's directive store.

Parameters:
DEPTH, 31, number of instruction words in memory; also the maximum legal word count.
ADDR_W, 5, instruction memory address width.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CYC, 1000000, maximum idle cycles allowed between accepted bytes inside a frame.

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-low
rx_valid  in  1  rx_data holds a byte
rx_data  in  8  received byte
rx_ready  out  1  loader can accept a byte
imem_we  out  1  one-cycle instruction write strobe
imem_addr  out  ADDR_W  write address (word index)
imem_wdata  out  32  instruction word
cpu_hold  out  1  holds the CPU in reset (PC=0) while high
load_done  out  1  last frame loaded and verified
err_code  out  2  00 none, 01 bad count, 10 checksum mismatch, 11 timeout
words_loaded  out  6  words written in the current or last frame

Behaviour:
- Reset (reset==0 at posedge clk) has priority over all other inputs.
  - State goes to IDLE.
  - rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=0, load_done=0, err_code=00, words_loaded=0.
  - Memory contents already written are left as they are.
- rx_ready is registered. It is 1 in every state from the first cycle after reset releases.
- A byte is accepted only on a cycle where rx_valid && rx_ready.
- Frame format: SYNC_BYTE, COUNT N, then 4N data bytes (each word MSB first), then CHK.
  - CHK = XOR of N and all 4N data bytes.
  - SYNC_BYTE is not part of CHK.
- States:
  - IDLE: a SYNC_BYTE byte moves to COUNT. Any other byte is discarded.
  - COUNT:
    - 1 <= N <= DEPTH: store N, clear the word index, byte index and running XOR, then go to DATA.
    - Any other N: go to ERR with err_code=01. No memory writes occur.
  - DATA:
    - Each byte is shifted into a 32-bit assembly register.
    - On the 4th byte of word k (0-based), imem_we=1 in the next cycle only, with imem_addr=k and imem_wdata equal to the assembled word.
    - words_loaded increments in the same cycle as that write.
    - After word N-1 is written, go to CHECK.
  - CHECK:
    - CHK equal to the running XOR: go to DONE.
    - Otherwise go to ERR with err_code=10.
  - DONE: load_done=1, cpu_hold=0.
  - ERR: load_done=0, cpu_hold remains 1, so the CPU never runs a partial or corrupt image.
- Entering COUNT from any state:
  - cpu_hold=1, load_done=0, err_code=00, words_loaded=0.
  - cpu_hold rises in the cycle after the SYNC byte is accepted.
- In DONE and ERR, a SYNC_BYTE restarts at COUNT. All other bytes are discarded.
- Timeout:
  - In COUNT, DATA and CHECK, a cycle counter clears on every accepted byte and increments otherwise.
  - When the counter reaches TIMEOUT_CYC, go to ERR with err_code=11.
  - Writes already issued stand.
- A SYNC_BYTE value arriving inside COUNT, DATA or CHECK is treated as ordinary data. There is no resync mid-frame.
- rx_valid gaps of any length below TIMEOUT_CYC do not affect the result.
- Data must be accepted back-to-back at one byte per cycle. A write issued in cycle t+1 never blocks the acceptance of a byte in that same cycle.
- Words with index >= N are never written.
- Latency:
  - 4th byte of a word accepted at cycle t -> imem_we high at t+1.
  - CHK accepted at cycle t -> load_done or err_code valid at t+1.

Test Plan:
1. Good load: A5, 02, 22 10 00 03, 36 10 00 0A, 1F.
   - Two writes: addr0=0x22100003, addr1=0x3610000A, each a one-cycle imem_we.
   - Then load_done=1, cpu_hold=0, words_loaded=2, err_code=00.
2. Same frame with CHK=1E.
   - Both writes still issued.
   - err_code=10, cpu_hold=1, load_done=0.
3. Bad count.
   - A5 00 -> err_code=01, no imem_we.
   - A5 20 (N=32) -> err_code=01, no imem_we.
   - A following good frame then completes normally.
4. Timeout, with TIMEOUT_CYC=16.
   - A5 01 22 10 00, then silence.
   - err_code=11 exactly 16 cycles after the last accepted byte; no imem_we.
5. Reset mid-frame.
   - Drop reset to 0 for one cycle after A5 02 22 10 00 03 36.
   - One write at addr0 occurred; all outputs return to reset values.
   - A fresh full frame then succeeds.
6. Handshake and framing.
   - Bytes 00 FF 13 in IDLE are ignored.
   - rx_valid toggled every other cycle during the test 1 frame gives the identical writes.
   - A5 received in DONE restarts the load and re-raises cpu_hold.

Source files
------------

// File: rtl/imem_prog_loader.sv
// Byte-stream program loader: unpacks framed UART bytes into 32-bit instruction
// writes and holds the CPU in reset until a complete, checksummed image is in place.
module imem_prog_loader #(
    parameter int         DEPTH       = 31,
    parameter int         ADDR_W      = 5,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [1:0]        err_code,
    output logic [5:0]        words_loaded
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERR} state_t;

    state_t            state, nextState;
    logic [1:0]        errNext;
    logic [TW-1:0]     idleCnt;
    logic [ADDR_W-1:0] countN, wordIdx;
    logic [1:0]        byteIdx;
    logic [23:0]       asmReg;
    logic [7:0]        runXor;

    logic accept, inFrame, timeoutHit, countOk, lastWord;

    assign accept     = rx_valid && rx_ready;
    assign inFrame    = (state == COUNT) || (state == DATA) || (state == CHECK);
    assign timeoutHit = inFrame && !accept && (idleCnt == TW'(TIMEOUT_CYC - 1));
    assign countOk    = (rx_data != 8'd0) && ({24'd0, rx_data} <= 32'(DEPTH));
    assign lastWord   = (byteIdx == 2'd3) && (wordIdx == countN - 1'b1);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        errNext   = err_code;
        case (state)
            IDLE, DONE, ERR:
                if (accept && rx_data == SYNC_BYTE) begin
                    nextState = COUNT;
                    errNext   = 2'b00;
                end
            COUNT:
                if (accept) begin
                    if (countOk) nextState = DATA;
                    else begin
                        nextState = ERR;
                        errNext   = 2'b01;
                    end
                end
            DATA:
                if (accept && lastWord) nextState = CHECK;
            CHECK:
                if (accept) begin
                    if (rx_data == runXor) nextState = DONE;
                    else begin
                        nextState = ERR;
                        errNext   = 2'b10;
                    end
                end
            default: nextState = IDLE;
        endcase
        // timeoutHit implies no byte this cycle, so it never competes with the cases above
        if (timeoutHit) begin
            nextState = ERR;
            errNext   = 2'b11;
        end
    end

    // Hold covers ERR too, so a partial or corrupt image never runs.
    always_comb begin
        cpu_hold  = (state == COUNT) || (state == DATA) || (state == CHECK) || (state == ERR);
        load_done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            err_code     <= 2'b00;
            words_loaded <= '0;
            idleCnt      <= '0;
            countN       <= '0;
            wordIdx      <= '0;
            byteIdx      <= '0;
            asmReg       <= '0;
            runXor       <= '0;
        end else begin
            rx_ready <= 1'b1;
            imem_we  <= 1'b0;
            err_code <= errNext;
            if (accept || !inFrame) idleCnt <= '0;
            else                    idleCnt <= idleCnt + 1'b1;
            case (state)
                IDLE, DONE, ERR:
                    if (accept && rx_data == SYNC_BYTE) words_loaded <= '0;
                COUNT:
                    if (accept) begin
                        countN  <= rx_data[ADDR_W-1:0];
                        wordIdx <= '0;
                        byteIdx <= '0;
                        runXor  <= rx_data;
                    end
                DATA:
                    if (accept) begin
                        asmReg  <= {asmReg[15:0], rx_data};
                        runXor  <= runXor ^ rx_data;
                        byteIdx <= byteIdx + 1'b1;
                        if (byteIdx == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_addr    <= wordIdx;
                            imem_wdata   <= {asmReg, rx_data};
                            words_loaded <= words_loaded + 6'd1;
                            wordIdx      <= wordIdx + 1'b1;
                        end
                    end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed bench: stimulus pushes expected instruction writes into a scoreboard
// queue; a forked monitor pops and checks every imem_we pulse.
module tb_imem_prog_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, imem_we, cpu_hold, load_done;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [1:0]  err_code;
    logic [5:0]  words_loaded;

    int tests = 0;
    int fails = 0;
    logic [36:0] sbQ[$];

    imem_prog_loader #(.DEPTH(31), .ADDR_W(5), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
        .err_code(err_code), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                if (sbQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", imem_addr, imem_wdata);
                end else begin
                    e = sbQ.pop_front();
                    check("wr_addr", {27'd0, imem_addr}, {27'd0, e[36:32]});
                    check("wr_data", imem_wdata, e[31:0]);
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic sendByte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic sendWord(input logic [31:0] w, input logic [4:0] addr, input bit expectWr, input int gap);
        if (expectWr) sbQ.push_back({addr, w});
        for (int i = 3; i >= 0; i--) begin
            sendByte(w[i*8 +: 8]);
            if (i != 0) idle(gap);
        end
        if (expectWr) check("we_latency", {31'd0, imem_we}, 32'd1);
        idle(gap);
    endtask

    task automatic goodFrame(input logic [7:0] chk, input int gap);
        sendByte(8'hA5); idle(gap);
        check("hold_rise", {31'd0, cpu_hold}, 32'd1);
        sendByte(8'h02); idle(gap);
        sendWord(32'h22100003, 5'd0, 1'b1, gap);
        sendWord(32'h3610000A, 5'd1, 1'b1, gap);
        sendByte(chk);
    endtask

    task automatic status(input string name, input logic done, input logic hold,
                          input logic [1:0] err, input logic [5:0] words);
        check({name, "_done"}, {31'd0, load_done}, {31'd0, done});
        check({name, "_hold"}, {31'd0, cpu_hold}, {31'd0, hold});
        check({name, "_err"}, {30'd0, err_code}, {30'd0, err});
        check({name, "_words"}, {26'd0, words_loaded}, {26'd0, words});
    endtask

    task automatic drained(input string name);
        idle(2);
        check(name, sbQ.size(), 32'd0);
        sbQ.delete();
    endtask

    initial begin
        fork monitor(); join_none
        idle(3);
        check("rst_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", {27'd0, imem_addr}, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        status("rst", 1'b0, 1'b0, 2'b00, 6'd0);
        reset = 1'b1;
        idle(1);
        check("ready_after_rst", {31'd0, rx_ready}, 32'd1);

        // Garbage in IDLE is dropped
        sendByte(8'h00); sendByte(8'hFF); sendByte(8'h13);
        idle(2);
        status("idle_junk", 1'b0, 1'b0, 2'b00, 6'd0);

        goodFrame(8'h1F, 0);
        status("good", 1'b1, 1'b0, 2'b00, 6'd2);
        drained("good_drained");

        // Restart from DONE, then bad checksum
        sendByte(8'hA5);
        status("restart", 1'b0, 1'b1, 2'b00, 6'd0);
        sendByte(8'h02);
        sendWord(32'h22100003, 5'd0, 1'b1, 0);
        sendWord(32'h3610000A, 5'd1, 1'b1, 0);
        sendByte(8'h1E);
        status("badchk", 1'b0, 1'b1, 2'b10, 6'd2);
        drained("badchk_drained");

        sendByte(8'hA5); sendByte(8'h00);
        status("cnt0", 1'b0, 1'b1, 2'b01, 6'd0);
        sendByte(8'hA5); sendByte(8'h20);
        status("cnt32", 1'b0, 1'b1, 2'b01, 6'd0);
        drained("badcnt_drained");
        goodFrame(8'h1F, 0);
        status("after_badcnt", 1'b1, 1'b0, 2'b00, 6'd2);
        drained("after_badcnt_drained");

        // rx_valid every other cycle
        goodFrame(8'h1F, 1);
        status("gapped", 1'b1, 1'b0, 2'b00, 6'd2);
        drained("gapped_drained");

        // Reset mid-frame after the first word landed
        sbQ.push_back({5'd0, 32'h22100003});
        sendByte(8'hA5); sendByte(8'h02);
        sendByte(8'h22); sendByte(8'h10); sendByte(8'h00); sendByte(8'h03);
        sendByte(8'h36);
        check("mid_words", {26'd0, words_loaded}, 32'd1);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        check("mid_rst_ready", {31'd0, rx_ready}, 32'd0);
        check("mid_rst_addr", {27'd0, imem_addr}, 32'd0);
        check("mid_rst_wdata", imem_wdata, 32'd0);
        status("mid_rst", 1'b0, 1'b0, 2'b00, 6'd0);
        drained("mid_drained");
        goodFrame(8'h1F, 0);
        status("after_rst", 1'b1, 1'b0, 2'b00, 6'd2);
        drained("after_rst_drained");

        // Timeout: 16 idle cycles after the last accepted byte
        sendByte(8'hA5); sendByte(8'h01);
        sendByte(8'h22); sendByte(8'h10); sendByte(8'h00);
        idle(15);
        check("to_early", {30'd0, err_code}, 32'd0);
        idle(1);
        status("timeout", 1'b0, 1'b1, 2'b11, 6'd0);
        drained("timeout_drained");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
